dcache_write_buffer: RTL and testbench

The dcache write buffer is a FIFO that holds committed stores between the store commit path and the dcache. It drains them to the two dcache banks in program order over a valid/ready port, and reports which bank each drained store targets. It also gives loads a same-cycle, byte-granular forward of the youngest buffered store data, so loads see pending stores before those stores reach the dcache.

---
 rtl/system_types_pkg.sv | 29 ++
 rtl/dcache_write_buffer_fwd.sv | 25 ++
 rtl/dcache_write_buffer.sv | 132 +++++++++++++
 tb/tb_dcache_write_buffer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/system_types_pkg.sv
// Shared types and sizing for the dcache write buffer.
package system_types_pkg;

    localparam int DCACHE_WB_ENTRIES         = 4;
    localparam int DCACHE_WORD_PA_WIDTH      = 32;
    // Two banks, interleaved on word address bit 0.
    localparam int DCACHE_WORD_ADDR_BANK_BIT = 0;
    localparam int DCACHE_WB_PTR_W           = $clog2(DCACHE_WB_ENTRIES);
    localparam int DCACHE_WB_OCC_W           = $clog2(DCACHE_WB_ENTRIES + 1);

    typedef struct packed {
        logic [DCACHE_WORD_PA_WIDTH-1:0] word_PA;
        logic [31:0]                     data;
        logic [3:0]                      byte_mask;
    } dcache_wb_entry_t;

    // New bytes replace old bytes wherever the new mask is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_data,
                                                input logic [31:0] new_data,
                                                input logic [3:0]  new_mask);
        logic [31:0] res;
        res = old_data;
        for (int b = 0; b < 4; b++) begin
            if (new_mask[b]) res[8*b +: 8] = new_data[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dcache_write_buffer_fwd.sv
// Per-lane youngest-match byte select over an age-ordered entry array (index 0 oldest).
module dcache_write_buffer_fwd
    import system_types_pkg::*;
(
    input  dcache_wb_entry_t [DCACHE_WB_ENTRIES-1:0] entries_by_age,
    input  logic [DCACHE_WB_ENTRIES-1:0]             match,
    output logic [3:0]                               fwd_byte_mask,
    output logic [31:0]                              fwd_data
);

    // Walking oldest to youngest lets the youngest matching writer win each lane.
    always_comb begin
        fwd_byte_mask = 4'h0;
        fwd_data      = 32'h0;
        for (int i = 0; i < DCACHE_WB_ENTRIES; i++) begin
            for (int b = 0; b < 4; b++) begin
                if (match[i] && entries_by_age[i].byte_mask[b]) begin
                    fwd_byte_mask[b]   = 1'b1;
                    fwd_data[8*b +: 8] = entries_by_age[i].data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dcache_write_buffer.sv
// Committed-store FIFO draining to the dcache in order, with byte-granular load forwarding.
// Optional store coalescing into the youngest entry: DCACHE_WRITE_BUFFER_COALESCE_EN.
module dcache_write_buffer
    import system_types_pkg::*;
(
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            enq_valid,
    input  logic [DCACHE_WORD_PA_WIDTH-1:0] enq_word_PA,
    input  logic [31:0]                     enq_data,
    input  logic [3:0]                      enq_byte_mask,
    output logic                            enq_ready,
    output logic                            drain_valid,
    output logic                            drain_bank,
    output logic [DCACHE_WORD_PA_WIDTH-1:0] drain_word_PA,
    output logic [31:0]                     drain_data,
    output logic [3:0]                      drain_byte_mask,
    input  logic                            drain_ready,
    input  logic                            fwd_valid,
    input  logic [DCACHE_WORD_PA_WIDTH-1:0] fwd_word_PA,
    output logic                            fwd_hit,
    output logic [3:0]                      fwd_byte_mask,
    output logic [31:0]                     fwd_data,
    output logic                            empty,
    output logic [DCACHE_WB_OCC_W-1:0]      occupancy
);

    dcache_wb_entry_t               entries_q [DCACHE_WB_ENTRIES];
    dcache_wb_entry_t               entries_d [DCACHE_WB_ENTRIES];
    logic [DCACHE_WB_PTR_W-1:0]     head_q, head_d;
    logic [DCACHE_WB_PTR_W-1:0]     tail_q, tail_d;
    logic [DCACHE_WB_OCC_W-1:0]     occ_q, occ_d;

    logic                           full;
    logic                           coalesce_match;
    logic                           enq_fire;
    logic                           drain_fire;
    logic [DCACHE_WB_PTR_W-1:0]     youngest_idx;
    dcache_wb_entry_t               head_entry;

    dcache_wb_entry_t [DCACHE_WB_ENTRIES-1:0] entries_by_age;
    logic [DCACHE_WB_ENTRIES-1:0]             fwd_match;

    assign full         = (occ_q == DCACHE_WB_OCC_W'(DCACHE_WB_ENTRIES));
    assign empty        = (occ_q == '0);
    assign occupancy    = occ_q;
    assign youngest_idx = tail_q - 1'b1;

`ifdef DCACHE_WRITE_BUFFER_COALESCE_EN
    // With two or more entries the youngest is never the head, so it cannot drain this cycle.
    assign coalesce_match = (occ_q >= DCACHE_WB_OCC_W'(2)) &&
                            (entries_q[youngest_idx].word_PA == enq_word_PA);
`else
    assign coalesce_match = 1'b0;
`endif

    assign enq_ready  = !full || coalesce_match;
    assign enq_fire   = enq_valid && enq_ready;
    assign drain_fire = drain_valid && drain_ready;

    assign head_entry      = entries_q[head_q];
    assign drain_valid     = !empty;
    assign drain_word_PA   = head_entry.word_PA;
    assign drain_data      = head_entry.data;
    assign drain_byte_mask = head_entry.byte_mask;
    assign drain_bank      = head_entry.word_PA[DCACHE_WORD_ADDR_BANK_BIT];

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        occ_d     = occ_q;
        if (enq_fire) begin
            if (coalesce_match) begin
                entries_d[youngest_idx].data      = merge_bytes(entries_q[youngest_idx].data,
                                                                enq_data, enq_byte_mask);
                entries_d[youngest_idx].byte_mask = entries_q[youngest_idx].byte_mask | enq_byte_mask;
            end else begin
                entries_d[tail_q].word_PA   = enq_word_PA;
                entries_d[tail_q].data      = enq_data;
                entries_d[tail_q].byte_mask = enq_byte_mask;
                tail_d                      = tail_q + 1'b1;
            end
        end
        if (drain_fire) begin
            head_d = head_q + 1'b1;
        end
        case ({enq_fire && !coalesce_match, drain_fire})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DCACHE_WB_ENTRIES; i++) begin
                entries_q[i] <= '0;
            end
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            occ_q     <= occ_d;
        end
    end

    // Only entries currently held are forwardable; a same-cycle enqueue is not yet stored.
    always_comb begin
        entries_by_age = '0;
        fwd_match      = '0;
        for (int i = 0; i < DCACHE_WB_ENTRIES; i++) begin
            entries_by_age[i] = entries_q[head_q + DCACHE_WB_PTR_W'(i)];
            fwd_match[i]      = fwd_valid &&
                                (DCACHE_WB_OCC_W'(i) < occ_q) &&
                                (entries_by_age[i].word_PA == fwd_word_PA);
        end
    end

    dcache_write_buffer_fwd u_fwd (
        .entries_by_age (entries_by_age),
        .match          (fwd_match),
        .fwd_byte_mask  (fwd_byte_mask),
        .fwd_data       (fwd_data)
    );

    assign fwd_hit = |fwd_byte_mask;

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Self-checking bench for dcache_write_buffer: queue-based reference model plus directed literals.
module tb_dcache_write_buffer;
    import system_types_pkg::*;

    localparam int N = DCACHE_WB_ENTRIES;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        enq_valid = 1'b0;
    logic [31:0] enq_word_PA = '0;
    logic [31:0] enq_data = '0;
    logic [3:0]  enq_byte_mask = '0;
    logic        enq_ready;
    logic        drain_valid;
    logic        drain_bank;
    logic [31:0] drain_word_PA;
    logic [31:0] drain_data;
    logic [3:0]  drain_byte_mask;
    logic        drain_ready = 1'b0;
    logic        fwd_valid = 1'b0;
    logic [31:0] fwd_word_PA = '0;
    logic        fwd_hit;
    logic [3:0]  fwd_byte_mask;
    logic [31:0] fwd_data;
    logic        empty;
    logic [DCACHE_WB_OCC_W-1:0] occupancy;

    int checks = 0;
    int errors = 0;
    int drained = 0;

    typedef struct {
        logic [31:0] pa;
        logic [31:0] data;
        logic [3:0]  mask;
    } m_entry_t;
    m_entry_t mq[$];

    dcache_write_buffer dut (
        .CLK(CLK), .RST(RST),
        .enq_valid(enq_valid), .enq_word_PA(enq_word_PA), .enq_data(enq_data),
        .enq_byte_mask(enq_byte_mask), .enq_ready(enq_ready),
        .drain_valid(drain_valid), .drain_bank(drain_bank), .drain_word_PA(drain_word_PA),
        .drain_data(drain_data), .drain_byte_mask(drain_byte_mask), .drain_ready(drain_ready),
        .fwd_valid(fwd_valid), .fwd_word_PA(fwd_word_PA), .fwd_hit(fwd_hit),
        .fwd_byte_mask(fwd_byte_mask), .fwd_data(fwd_data),
        .empty(empty), .occupancy(occupancy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_coalesce();
`ifdef DCACHE_WRITE_BUFFER_COALESCE_EN
        return (mq.size() >= 2) && (mq[mq.size()-1].pa == enq_word_PA);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic m_ready();
        return (mq.size() < N) || m_coalesce();
    endfunction

    // Youngest store holding each lane supplies it.
    task automatic m_fwd(output logic [3:0] m, output logic [31:0] d);
        m = '0;
        d = '0;
        if (fwd_valid) begin
            for (int b = 0; b < 4; b++) begin
                for (int i = mq.size() - 1; i >= 0; i--) begin
                    if (mq[i].pa == fwd_word_PA && mq[i].mask[b]) begin
                        m[b] = 1'b1;
                        d[8*b +: 8] = mq[i].data[8*b +: 8];
                        break;
                    end
                end
            end
        end
    endtask

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            mq.delete();
        end else begin
            logic ef, df, co;
            m_entry_t e;
            co = m_coalesce();
            ef = enq_valid && m_ready();
            df = drain_ready && (mq.size() > 0);
            if (ef) begin
                if (co) begin
                    e = mq[mq.size()-1];
                    for (int b = 0; b < 4; b++)
                        if (enq_byte_mask[b]) e.data[8*b +: 8] = enq_data[8*b +: 8];
                    e.mask = e.mask | enq_byte_mask;
                    mq[mq.size()-1] = e;
                end else begin
                    e.pa = enq_word_PA; e.data = enq_data; e.mask = enq_byte_mask;
                    mq.push_back(e);
                end
            end
            if (df) begin
                void'(mq.pop_front());
                drained++;
            end
        end
    end

    always @(negedge CLK) begin
        if (!RST) begin
            logic [3:0]  fm;
            logic [31:0] fd;
            m_fwd(fm, fd);
            chk("enq_ready", {31'b0, enq_ready}, {31'b0, m_ready()});
            chk("drain_valid", {31'b0, drain_valid}, {31'b0, mq.size() > 0});
            chk("occupancy", 32'(occupancy), 32'(mq.size()));
            chk("empty", {31'b0, empty}, {31'b0, mq.size() == 0});
            if (mq.size() > 0) begin
                chk("drain_word_PA", drain_word_PA, mq[0].pa);
                chk("drain_data", drain_data, mq[0].data);
                chk("drain_byte_mask", {28'b0, drain_byte_mask}, {28'b0, mq[0].mask});
                chk("drain_bank", {31'b0, drain_bank}, {31'b0, mq[0].pa[0]});
            end
            chk("fwd_byte_mask", {28'b0, fwd_byte_mask}, {28'b0, fm});
            chk("fwd_data", fwd_data, fd);
            chk("fwd_hit", {31'b0, fwd_hit}, {31'b0, fm != 4'h0});
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        enq_valid = 1'b0;
        drain_ready = 1'b0;
        fwd_valid = 1'b0;
    endtask

    task automatic enq(input logic [31:0] pa, input logic [31:0] d, input logic [3:0] m);
        enq_valid = 1'b1; enq_word_PA = pa; enq_data = d; enq_byte_mask = m;
    endtask

    initial begin
        int start_drained;
        #12 RST = 1'b0;
        cyc();

        chk("rst_drain_valid", {31'b0, drain_valid}, 32'd0);
        chk("rst_enq_ready", {31'b0, enq_ready}, 32'd1);
        chk("rst_empty", {31'b0, empty}, 32'd1);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_drain_data", drain_data, 32'd0);
        chk("rst_drain_PA", drain_word_PA, 32'd0);

        enq(32'h0000_0010, 32'hAABB_CCDD, 4'hF);
        drain_ready = 1'b1;
        cyc();
        enq_valid = 1'b0;
        chk("t1_drain_valid", {31'b0, drain_valid}, 32'd1);
        chk("t1_drain_bank", {31'b0, drain_bank}, 32'd0);
        chk("t1_drain_data", drain_data, 32'hAABB_CCDD);
        cyc();
        chk("t1_empty", {31'b0, empty}, 32'd1);
        idle_inputs();

        for (int i = 0; i < 4; i++) begin
            enq(32'h100 + 32'(i), $urandom, 4'hF);
            cyc();
        end
        enq_valid = 1'b0;
        chk("full_enq_ready", {31'b0, enq_ready}, 32'd0);
        chk("full_occupancy", 32'(occupancy), 32'd4);
        enq(32'h200, 32'h5555_5555, 4'hF);
        drain_ready = 1'b1;
        #1;
        chk("full_simul_enq_ready", {31'b0, enq_ready}, 32'd0);
        cyc();
        idle_inputs();
        chk("full_after_drain_occ", 32'(occupancy), 32'd3);
        drain_ready = 1'b1;
        repeat (3) cyc();
        drain_ready = 1'b0;
        chk("full_drained_empty", {31'b0, empty}, 32'd1);

        enq(32'h20, 32'h0000_1111, 4'h3);
        cyc();
        enq(32'h20, 32'h2200_2200, 4'h6);
        cyc();
        enq_valid = 1'b0;
        fwd_valid = 1'b1;
        fwd_word_PA = 32'h20;
        #1;
        chk("fwd_mask", {28'b0, fwd_byte_mask}, 32'h7);
        chk("fwd_data_lit", fwd_data, 32'h0000_2211);
        chk("fwd_hit_lit", {31'b0, fwd_hit}, 32'd1);
        fwd_word_PA = 32'h24;
        #1;
        chk("fwd_miss_hit", {31'b0, fwd_hit}, 32'd0);
        fwd_valid = 1'b0;
        fwd_word_PA = 32'h20;
        #1;
        chk("fwd_off_mask", {28'b0, fwd_byte_mask}, 32'd0);
        chk("fwd_off_data", fwd_data, 32'd0);
        drain_ready = 1'b1;
        repeat (2) cyc();
        idle_inputs();

        start_drained = drained;
        for (int i = 0; i < 12; i++) begin
            enq(32'h300 + 32'(i), $urandom, 4'($urandom));
            drain_ready = 1'($urandom_range(0, 1));
            cyc();
            while (!enq_ready) begin
                drain_ready = 1'b1;
                cyc();
            end
        end
        enq_valid = 1'b0;
        drain_ready = 1'b1;
        repeat (N + 1) cyc();
        idle_inputs();
        chk("wrap_drain_count", 32'(drained - start_drained), 32'd12);
        chk("wrap_empty", {31'b0, empty}, 32'd1);

`ifdef DCACHE_WRITE_BUFFER_COALESCE_EN
        for (int i = 0; i < 4; i++) begin
            enq(32'h400 + 32'(i), 32'h0000_00A0 + 32'(i), 4'h1);
            cyc();
        end
        enq(32'h403, 32'h7700_0000, 4'h8);
        #1;
        chk("coal_enq_ready", {31'b0, enq_ready}, 32'd1);
        cyc();
        enq_valid = 1'b0;
        chk("coal_occupancy", 32'(occupancy), 32'd4);
        fwd_valid = 1'b1;
        fwd_word_PA = 32'h403;
        #1;
        chk("coal_tail_mask", {28'b0, fwd_byte_mask}, 32'h9);
        chk("coal_tail_data", fwd_data, 32'h7700_00A3);
        fwd_valid = 1'b0;
        drain_ready = 1'b1;
        repeat (4) cyc();
        idle_inputs();
`endif

        for (int i = 0; i < 400; i++) begin
            enq_valid = 1'($urandom_range(0, 1));
            enq_word_PA = 32'h20 + 32'($urandom_range(0, 3));
            enq_data = $urandom;
            enq_byte_mask = 4'($urandom);
            drain_ready = ($urandom_range(0, 3) == 0);
            fwd_valid = 1'($urandom_range(0, 1));
            fwd_word_PA = 32'h20 + 32'($urandom_range(0, 3));
            cyc();
        end
        idle_inputs();
        drain_ready = 1'b1;
        repeat (N + 1) cyc();
        idle_inputs();

        for (int i = 0; i < 3; i++) begin
            enq(32'h500 + 32'(i), $urandom, 4'hF);
            cyc();
        end
        enq_valid = 1'b0;
        chk("rstmid_occ", 32'(occupancy), 32'd3);
        #2 RST = 1'b1;
        #1;
        chk("rstmid_drain_valid", {31'b0, drain_valid}, 32'd0);
        chk("rstmid_empty", {31'b0, empty}, 32'd1);
        chk("rstmid_occupancy", 32'(occupancy), 32'd0);
        #10 RST = 1'b0;
        cyc();
        chk("post_rst_enq_ready", {31'b0, enq_ready}, 32'd1);
        repeat (2) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
